// File: rtl/note_player.sv
// Song playback: walks the note RAM at beat rate, decodes each string/fret bitmap
// into a note index, and drives a square-wave sample stream for the codec.
module note_player #(
    parameter int                  ADDR_W   = 6,
    parameter int                  SAMPLE_W = 24,
    parameter logic [SAMPLE_W-1:0] AMPL     = 24'h100000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                stop,
    input  logic                beat,
    input  logic [ADDR_W-1:0]   last_addr,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [31:0]         rd_data,
    output logic                playing,
    output logic                note_valid,
    output logic [4:0]          note_idx,
    input  logic                sample_req,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [SAMPLE_W-1:0] NEG_AMPL = -AMPL;

    // Half-period in clk cycles for semitone n above E2.
    function automatic logic [18:0] half_period(input logic [4:0] n);
        case (n)
            5'd0:  half_period = 19'd303370;
            5'd1:  half_period = 19'd286346;
            5'd2:  half_period = 19'd270273;
            5'd3:  half_period = 19'd255105;
            5'd4:  half_period = 19'd240787;
            5'd5:  half_period = 19'd227273;
            5'd6:  half_period = 19'd214517;
            5'd7:  half_period = 19'd202477;
            5'd8:  half_period = 19'd191113;
            5'd9:  half_period = 19'd180387;
            5'd10: half_period = 19'd170263;
            5'd11: half_period = 19'd160707;
            5'd12: half_period = 19'd151686;
            5'd13: half_period = 19'd143173;
            5'd14: half_period = 19'd135137;
            5'd15: half_period = 19'd127552;
            5'd16: half_period = 19'd120394;
            5'd17: half_period = 19'd113636;
            5'd18: half_period = 19'd107258;
            5'd19: half_period = 19'd101238;
            5'd20: half_period = 19'd95556;
            5'd21: half_period = 19'd90193;
            5'd22: half_period = 19'd85131;
            5'd23: half_period = 19'd80353;
            5'd24: half_period = 19'd75843;
            5'd25: half_period = 19'd71586;
            5'd26: half_period = 19'd67569;
            5'd27: half_period = 19'd63777;
            default: half_period = 19'd60197;
        endcase
    endfunction

    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_note_valid;
    logic [4:0]          r_note_idx;
    logic [18:0]         r_half;
    logic [18:0]         r_cnt;
    logic                r_phase;
    logic [SAMPLE_W-1:0] r_sample;
    logic                r_sample_valid;

    logic                w_hit;
    logic [4:0]          w_bit;
    logic [4:0]          w_fret;
    logic [4:0]          w_string;
    logic [4:0]          w_open;
    logic [4:0]          w_semi;
    logic [18:0]         w_half;
    logic [SAMPLE_W-1:0] w_level;

    // Highest set bit wins; bit k encodes fret k/6 on string k%6.
    always_comb begin
        w_hit = |rd_data[29:0];
        w_bit = '0;
        for (int unsigned k = 0; k < 30; k++) begin
            if (rd_data[k]) w_bit = 5'(k);
        end
        w_fret   = w_bit / 5'd6;
        w_string = w_bit % 5'd6;
        case (w_string)
            5'd0:    w_open = 5'd0;
            5'd1:    w_open = 5'd5;
            5'd2:    w_open = 5'd10;
            5'd3:    w_open = 5'd15;
            5'd4:    w_open = 5'd19;
            default: w_open = 5'd24;
        endcase
        w_semi = w_open + w_fret;
        w_half = half_period(w_semi);
    end

    always_comb begin
        w_level = '0;
        if (r_note_valid) w_level = r_phase ? NEG_AMPL : AMPL;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_note_valid   <= 1'b0;
            r_note_idx     <= '0;
            r_half         <= '0;
            r_cnt          <= '0;
            r_phase        <= 1'b0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= sample_req;
            if (sample_req) r_sample <= w_level;

            // The old note keeps running through FETCH/LATCH; LATCH below overrides.
            if (r_note_valid) begin
                if (r_cnt == r_half - 19'd1) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_cnt <= r_cnt + 19'd1;
                end
            end

            if (stop && r_state != S_IDLE) begin
                r_state      <= S_IDLE;
                r_note_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state <= S_FETCH;
                            r_addr  <= '0;
                        end
                    end
                    S_FETCH: r_state <= S_LATCH;
                    S_LATCH: begin
                        r_cnt        <= '0;
                        r_phase      <= 1'b0;
                        r_note_valid <= w_hit;
                        if (w_hit) begin
                            r_note_idx <= w_bit;
                            r_half     <= w_half;
                        end
                        r_state <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (beat) begin
                            if (r_addr == last_addr) begin
                                r_state <= S_DONE;
                            end else begin
                                r_addr  <= r_addr + 1'b1;
                                r_state <= S_FETCH;
                            end
                        end
                    end
                    S_DONE: begin
                        r_note_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign rd_addr      = r_addr;
    assign playing      = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign note_valid   = r_note_valid;
    assign note_idx     = r_note_idx;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;

endmodule
